// File: rtl/tcdm_pkg.sv
// Purpose: shared types and constants for the TCDM SRAM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: bus widths, FSM state enum, default error read data, response struct.
package tcdm_pkg;

  localparam int TCDM_AW  = 32;
  localparam int TCDM_DW  = 32;
  localparam int TCDM_BEW = 4;

  // Read data returned for an out-of-range read; easy to spot in a dump.
  localparam logic [TCDM_DW-1:0] TCDM_ERR_RDATA = 32'hBADC_AB1E;

  typedef enum logic {
    INIT,
    READY
  } state_e;

  typedef struct packed {
    logic               valid;
    logic               opc;
    logic [TCDM_DW-1:0] rdata;
  } resp_t;

endpackage

// File: rtl/tcdm_resp_pipe.sv
// Purpose: delays a response by a fixed number of cycles.
// Latency: LATENCY cycles from resp_in to resp_out.
// Backpressure: none; advances every cycle, reset empties every stage.
// Ports: clk_i/rst_ni clock and async active-low clear; resp_in response
//        captured at the grant edge; resp_out final stage.
module tcdm_resp_pipe
  import tcdm_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  resp_t resp_in,
  output resp_t resp_out
);

  resp_t stage [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= resp_in;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign resp_out = stage[LATENCY-1];

endmodule

// File: rtl/tcdm_sram_slave.sv
// Purpose: TCDM responder serving requests from a local word-addressed array.
// Latency: response LATENCY cycles after grant; zeroing sweep of NUM_WORDS cycles after reset.
// Backpressure: grants every request once READY; no grant during the sweep.
// Ports: clk_i/rst_ni clock and async active-low reset; tcdm_req/add/wen/wdata/be
//        request; tcdm_gnt_o grant; tcdm_r_rdata/opc/valid response; init_done_o sweep done.
module tcdm_sram_slave
  import tcdm_pkg::*;
#(
  parameter int                 NUM_WORDS = 256,
  parameter logic [TCDM_AW-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                 LATENCY   = 1,
  parameter logic [TCDM_DW-1:0] ERR_RDATA = TCDM_ERR_RDATA
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tcdm_req_i,
  input  logic [TCDM_AW-1:0]  tcdm_add_i,
  input  logic                tcdm_wen_i,
  input  logic [TCDM_DW-1:0]  tcdm_wdata_i,
  input  logic [TCDM_BEW-1:0] tcdm_be_i,
  output logic                tcdm_gnt_o,
  output logic [TCDM_DW-1:0]  tcdm_r_rdata_o,
  output logic                tcdm_r_opc_o,
  output logic                tcdm_r_valid_o,
  output logic                init_done_o
);

  localparam int IDX_W = $clog2(NUM_WORDS);

  logic [TCDM_DW-1:0] mem [NUM_WORDS];

  state_e             state;
  logic [IDX_W-1:0]   cnt;
  logic [TCDM_AW-1:0] off;
  logic               in_range;
  logic [IDX_W-1:0]   idx;
  resp_t              resp_in;
  resp_t              resp_out;

  // Unsigned subtract: addresses below BASE_ADDR wrap high and fall out of range.
  assign off      = tcdm_add_i - BASE_ADDR;
  assign in_range = off < TCDM_AW'(4 * NUM_WORDS);
  assign idx      = off[IDX_W+1:2];

  assign tcdm_gnt_o = tcdm_req_i && (state == READY);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= INIT;
      cnt         <= '0;
      init_done_o <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == IDX_W'(NUM_WORDS - 1)) begin
        state       <= READY;
        init_done_o <= 1'b1;
      end
    end
  end

  // Array has no reset; the sweep clears it instead.
  always_ff @(posedge clk_i) begin
    if (state == INIT) begin
      mem[cnt] <= '0;
    end else if (tcdm_gnt_o && !tcdm_wen_i && in_range) begin
      for (int k = 0; k < TCDM_BEW; k++) begin
        if (tcdm_be_i[k]) mem[idx][8*k +: 8] <= tcdm_wdata_i[8*k +: 8];
      end
    end
  end

  // Read data is taken before the grant edge, so a write granted in the
  // previous cycle is already visible.
  always_comb begin
    resp_in = '0;
    if (tcdm_gnt_o) begin
      resp_in.valid = 1'b1;
      resp_in.opc   = ~in_range;
      if (tcdm_wen_i) resp_in.rdata = in_range ? mem[idx] : ERR_RDATA;
    end
  end

  tcdm_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .resp_in  (resp_in),
    .resp_out (resp_out)
  );

  assign tcdm_r_valid_o = resp_out.valid;
  assign tcdm_r_opc_o   = resp_out.opc;
  assign tcdm_r_rdata_o = resp_out.rdata;

endmodule
